skid_pipe_stage: RTL

- Two-entry valid/ready skid buffer that sits directly upstream of the registered driver stage (DFF driver feeding the buffered hierarchical load module).
- Decouples the driver's capture timing from the upstream producer.
- Registers all data and flow-control state so the driver's D input and clock pin see a clean, registered source.
- Provides a saturating stall counter for backpressure observability.

---
 rtl/skid_pipe_stage.sv | 88 ++++++++
 1 files changed

// File: rtl/skid_pipe_stage.sv
// rtl/skid_pipe_stage.sv - two-entry valid/ready skid buffer with saturating stall counter
// All outputs decode from registered state only, so the downstream driver sees a clean source.
module skid_pipe_stage #(
    parameter int WIDTH   = 1,
    parameter int STALL_W = 8
) (
    input  logic               CK,
    input  logic               RN,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         occ,
    input  logic               clr_stall,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    state_t           state;
    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_reg;
    assign occ       = state;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Registers load only on in_fire, so X on in_data while idle never reaches storage.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state    <= EMPTY;
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state    <= ONE;
                        main_reg <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_reg <= in_data;
                    end else if (in_fire) begin
                        state    <= FULL;
                        skid_reg <= in_data;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state    <= ONE;
                        main_reg <= skid_reg;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Clear wins over increment; the count saturates instead of wrapping.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            stall_cnt <= '0;
        end else if (clr_stall) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
